// File: rtl/ebox_mem_req.sv
// EBOX memory request initiator.
// Turns one-cycle microcode memory commands into held MBOX read/write/RPW cycles.
module ebox_mem_req #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          cmdRead,
   input  logic          cmdWrite,
   input  logic          cmdPSE,
   input  logic [13:35]  cmdVMA,
   input  logic [0:35]   cmdData,
   output logic          busy,
   output logic          paused,
   output logic          done,
   output logic [0:35]   dataOut,
   output logic          pageFail,
   output logic [0:10]   pfCode,
   output logic          timeout,
   output logic [13:35]  EBOX_VMA,
   output logic          req,
   output logic          read,
   output logic          write,
   output logic          PSE,
   output logic [0:35]   cacheDataWrite,
   input  logic [0:35]   cacheDataRead,
   input  logic [0:10]   pfDisp,
   input  logic          mboxResp
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RREQ   = 3'd1;
   localparam logic [2:0] ST_RWAIT  = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_WREQ   = 3'd4;
   localparam logic [2:0] ST_WWAIT  = 3'd5;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   logic [2:0]   state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [13:35] vma_q, vma_d;
   logic [0:35]  cdw_q, cdw_d;
   logic [0:35]  dout_q, dout_d;
   logic [0:10]  pfc_q, pfc_d;
   logic         pse_q, pse_d;
   logic         done_q, done_d;
   logic         pf_q, pf_d;
   logic         to_q, to_d;
   logic [7:0]   cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   // Next-state and datapath capture for the request sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vma_d   = vma_q;
      cdw_d   = cdw_q;
      dout_d  = dout_q;
      pfc_d   = pfc_q;
      pse_d   = pse_q;
      done_d  = 1'b0;
      pf_d    = 1'b0;
      to_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && (cmdRead != cmdWrite)) begin
               state_d = cmdRead ? ST_RREQ : ST_WREQ;
               pse_d   = cmdRead & cmdPSE;
               vma_d   = cmdVMA;
               cdw_d   = cmdData;
               cnt_d   = 8'd0;
            end
         end
         ST_PAUSED: begin
            // write half of RPW reuses the held VMA
            if (start && cmdWrite) begin
               state_d = ST_WREQ;
               cdw_d   = cmdData;
               cnt_d   = 8'd0;
            end
         end
         ST_RREQ: state_d = ST_RWAIT;
         ST_WREQ: state_d = ST_WWAIT;
         ST_RWAIT, ST_WWAIT: begin
            if (mboxResp) begin
               cdw_d = '0;
               if (pfDisp != '0) begin
                  pfc_d   = pfDisp;
                  pf_d    = 1'b1;
                  pse_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  done_d = 1'b1;
                  if (state_q == ST_RWAIT) begin
                     dout_d  = cacheDataRead;
                     state_d = pse_q ? ST_PAUSED : ST_IDLE;
                     pse_d   = pse_q;
                  end else begin
                     state_d = ST_IDLE;
                     pse_d   = 1'b0;
                  end
               end
            end else if (cnt_inc == TO_LIM) begin
               to_d    = 1'b1;
               cdw_d   = '0;
               pse_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and captured-value registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         vma_q   <= '0;
         cdw_q   <= '0;
         dout_q  <= '0;
         pfc_q   <= '0;
         pse_q   <= 1'b0;
         done_q  <= 1'b0;
         pf_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vma_q   <= vma_d;
         cdw_q   <= cdw_d;
         dout_q  <= dout_d;
         pfc_q   <= pfc_d;
         pse_q   <= pse_d;
         done_q  <= done_d;
         pf_q    <= pf_d;
         to_q    <= to_d;
      end
   end

   assign busy           = (state_q == ST_RREQ) || (state_q == ST_RWAIT) ||
                           (state_q == ST_WREQ) || (state_q == ST_WWAIT);
   assign paused         = (state_q == ST_PAUSED);
   assign req            = (state_q == ST_RREQ) || (state_q == ST_WREQ);
   assign read           = (state_q == ST_RREQ) || (state_q == ST_RWAIT);
   assign write          = (state_q == ST_WREQ) || (state_q == ST_WWAIT);
   assign PSE            = pse_q;
   assign EBOX_VMA       = vma_q;
   assign cacheDataWrite = cdw_q;
   assign dataOut        = dout_q;
   assign pfCode         = pfc_q;
   assign done           = done_q;
   assign pageFail       = pf_q;
   assign timeout        = to_q;

endmodule

// File: tb/tb_ebox_mem_req.sv
// Bench for ebox_mem_req.
// Transaction-level model builds the expected per-cycle output trace.
module tb_ebox_mem_req;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         reset, start, cmdRead, cmdWrite, cmdPSE, mboxResp;
   logic [13:35] cmdVMA, EBOX_VMA;
   logic [0:35]  cmdData, dataOut, cacheDataWrite, cacheDataRead;
   logic [0:10]  pfDisp, pfCode;
   logic         busy, paused, done, pageFail, timeout;
   logic         req, read, write, PSE;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // expected outputs for the current cycle
   logic [8:0]   e_ctl;
   logic [13:35] e_vma;
   logic [0:35]  e_cdw, e_dout;
   logic [0:10]  e_pfc;

   // architectural model state
   logic [13:35] m_vma;
   logic [0:35]  m_dout;
   logic [0:10]  m_pfc;
   bit           m_paused;

   logic [8:0] ctl;
   assign ctl = {busy, paused, done, pageFail, timeout, req, read, write, PSE};

   always #5 clk = ~clk;

   ebox_mem_req #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cmdRead(cmdRead), .cmdWrite(cmdWrite), .cmdPSE(cmdPSE),
      .cmdVMA(cmdVMA), .cmdData(cmdData),
      .busy(busy), .paused(paused), .done(done), .dataOut(dataOut),
      .pageFail(pageFail), .pfCode(pfCode), .timeout(timeout),
      .EBOX_VMA(EBOX_VMA), .req(req), .read(read), .write(write),
      .PSE(PSE), .cacheDataWrite(cacheDataWrite),
      .cacheDataRead(cacheDataRead), .pfDisp(pfDisp), .mboxResp(mboxResp)
   );

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s t=%0t got=%0o want=%0o", n, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ctl{busy,paused,done,pf,to,req,rd,wr,pse}", 64'(ctl), 64'(e_ctl));
         chk("EBOX_VMA", 64'(EBOX_VMA), 64'(e_vma));
         chk("cacheDataWrite", 64'(cacheDataWrite), 64'(e_cdw));
         chk("dataOut", 64'(dataOut), 64'(e_dout));
         chk("pfCode", 64'(pfCode), 64'(e_pfc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      start = 0; cmdRead = 0; cmdWrite = 0; cmdPSE = 0;
      mboxResp = 0; pfDisp = '0; cacheDataRead = '0;
   endtask

   task automatic set_idle();
      e_ctl  = m_paused ? 9'h081 : 9'h000;
      e_vma  = m_vma;
      e_cdw  = '0;
      e_dout = m_dout;
      e_pfc  = m_pfc;
   endtask

   // dly: WAIT cycle (1-based) carrying the response; >TO means none
   task automatic xact(input bit rd, input bit wr, input bit pse,
                       input logic [13:35] vma, input logic [0:35] wd,
                       input int dly, input logic [0:35] rdat,
                       input logic [0:10] pf);
      bit acc, isrd, p;
      logic [13:35] v;
      acc  = m_paused ? wr : (rd != wr);
      isrd = !m_paused && rd;
      p    = isrd ? pse : m_paused;
      v    = m_paused ? m_vma : vma;
      set_idle();
      start = 1; cmdRead = rd; cmdWrite = wr; cmdPSE = pse;
      cmdVMA = vma; cmdData = wd;
      tick();
      clr_in();
      if (!acc) begin
         set_idle();
         tick();
         return;
      end
      m_vma  = v;
      e_ctl  = {1'b1, 4'b0000, 1'b1, isrd, !isrd, p};
      e_vma  = v;
      e_cdw  = wd;
      e_dout = m_dout;
      e_pfc  = m_pfc;
      // response during the request cycle must be ignored
      mboxResp = 1; pfDisp = 11'o3; cacheDataRead = 36'o7070;
      tick();
      clr_in();
      e_ctl[3] = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         start = (i == 1); cmdRead = (i == 1); cmdVMA = 23'o17;
         if (i == dly) begin
            mboxResp = 1; pfDisp = pf; cacheDataRead = rdat;
         end
         tick();
         clr_in();
         if (i == dly) break;
      end
      if (dly >= 1 && dly <= TO) begin
         if (pf != '0) begin
            m_pfc = pf; m_paused = 0;
            set_idle(); e_ctl[5] = 1'b1;
         end else begin
            if (isrd) m_dout = rdat;
            m_paused = isrd && pse;
            set_idle(); e_ctl[6] = 1'b1;
         end
      end else begin
         m_paused = 0;
         set_idle(); e_ctl[4] = 1'b1;
      end
      tick();
      set_idle();
      tick();
   endtask

   initial begin
      reset = 1; clr_in(); cmdVMA = '0; cmdData = '0;
      m_vma = '0; m_dout = '0; m_pfc = '0; m_paused = 0;
      @(posedge clk); #1;
      set_idle(); chk_en = 1;
      tick();
      reset = 0;
      tick();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_dataOut", 64'(dataOut), 64'(0));

      // plain read, 1-cycle MBOX
      xact(1, 0, 0, 23'o100, 36'o0, 1, 36'o123456701234, 11'o0);
      chk("rd_dataOut", 64'(dataOut), 64'(36'o123456701234));
      chk("rd_vma", 64'(EBOX_VMA), 64'(23'o100));
      chk("rd_busy", 64'(busy), 64'(0));

      // write, slower MBOX
      xact(0, 1, 0, 23'o777, 36'o777777777777, 3, 36'o0, 11'o0);
      chk("wr_write", 64'(write), 64'(0));
      chk("wr_cdw", 64'(cacheDataWrite), 64'(0));

      // read-pause-write
      xact(1, 0, 1, 23'o2000, 36'o0, 2, 36'o1111, 11'o0);
      chk("rpw_paused", 64'(paused), 64'(1));
      chk("rpw_pse", 64'(PSE), 64'(1));
      xact(1, 0, 0, 23'o6, 36'o0, 1, 36'o0, 11'o0);
      xact(0, 1, 0, 23'o5, 36'o4242, 1, 36'o0, 11'o0);
      chk("rpw_vma", 64'(EBOX_VMA), 64'(23'o2000));
      chk("rpw_pse_end", 64'(PSE), 64'(0));
      chk("rpw_paused_end", 64'(paused), 64'(0));

      // page fail on read, and on RPW read
      xact(1, 0, 0, 23'o300, 36'o0, 2, 36'o5555, 11'o1234);
      chk("pf_code", 64'(pfCode), 64'(11'o1234));
      chk("pf_dataOut", 64'(dataOut), 64'(36'o1111));
      xact(1, 0, 1, 23'o301, 36'o0, 1, 36'o6666, 11'o7);
      chk("pf_rpw_paused", 64'(paused), 64'(0));

      // timeouts, and a response on the last allowed cycle
      xact(1, 0, 0, 23'o400, 36'o0, 99, 36'o0, 11'o0);
      xact(0, 1, 0, 23'o401, 36'o12, 99, 36'o0, 11'o0);
      xact(1, 0, 0, 23'o402, 36'o0, TO, 36'o321, 11'o0);
      chk("late_dataOut", 64'(dataOut), 64'(36'o321));

      // illegal commands
      xact(1, 1, 0, 23'o500, 36'o1, 1, 36'o0, 11'o0);
      xact(0, 0, 1, 23'o501, 36'o1, 1, 36'o0, 11'o0);

      // reset in the middle of RWAIT, response arrives after reset
      set_idle();
      start = 1; cmdRead = 1; cmdVMA = 23'o4444; cmdData = 36'o55;
      tick();
      clr_in();
      e_ctl = 9'h10c; e_vma = 23'o4444; e_cdw = 36'o55;
      tick();
      e_ctl = 9'h104;
      reset = 1;
      tick();
      reset = 0;
      m_vma = '0; m_dout = '0; m_pfc = '0; m_paused = 0;
      set_idle();
      mboxResp = 1; cacheDataRead = 36'o777; pfDisp = 11'o0;
      tick();
      clr_in();
      tick();
      chk("rst2_dataOut", 64'(dataOut), 64'(0));
      chk("rst2_done", 64'(done), 64'(0));

      xact(1, 0, 0, 23'o7, 36'o0, 2, 36'o42, 11'o0);
      chk("post_dataOut", 64'(dataOut), 64'(36'o42));

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
